tlb_entry_array: RTL and testbench

- Holds the 8-entry joint TLB and feeds the full entry vector combinationally to the downstream fetch- and data-side lookup stages.
- Executes the CP0 TLB maintenance instructions TLBR, TLBWI, TLBWR and TLBP through a valid/ready handshake, with a small FSM.
- Maintains the Random register used by TLBWR.
- Sits between the CP0 register file and the lookup stages.

---
 rtl/tlb_entry_array_pkg.sv | 74 +++++++
 rtl/onehot_bin8.sv | 28 ++
 rtl/tlb_random.sv | 40 ++++
 rtl/tlb_entry_array.sv | 139 +++++++++++++
 tb/tb_tlb_entry_array.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_entry_array_pkg.sv
// Shared types for the 8-entry joint TLB and its maintenance ops.
// Optional Random lower bound from Wired: TLB_RANDOM_WIRED_EN.
package tlb_entry_array_pkg;

  localparam int NENTRY = 8;
  localparam int IDX_W = 3;
  localparam int TLB_W = 78;
  localparam logic [IDX_W-1:0] RANDOM_RST = 3'd7;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } TLB_t;

  typedef struct packed {
    logic        p;
    logic [27:0] zero;
    logic [2:0]  index;
  } Index_t;

  typedef enum logic [1:0] {
    TLBR  = 2'd0,
    TLBWI = 2'd1,
    TLBWR = 2'd2,
    TLBP  = 2'd3
  } TLBOp_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    PROBE,
    RESP
  } state_t;

  // EntryLo: {PFN[19:0], C[2:0], D, V, G}
  function automatic TLB_t make_entry(
    input logic [26:0] hi,
    input logic [25:0] lo0,
    input logic [25:0] lo1
  );
    TLB_t e;
    e.vpn2 = hi[26:8];
    e.asid = hi[7:0];
    e.g    = lo0[0] & lo1[0];
    e.pfn0 = lo0[25:6];
    e.c0   = lo0[5:3];
    e.d0   = lo0[2];
    e.v0   = lo0[1];
    e.pfn1 = lo1[25:6];
    e.c1   = lo1[5:3];
    e.d1   = lo1[2];
    e.v1   = lo1[1];
    return e;
  endfunction

  function automatic logic tlb_match(
    input TLB_t        e,
    input logic [26:0] hi
  );
    return (e.vpn2 == hi[26:8]) &&
           (e.g || (e.asid == hi[7:0]));
  endfunction

endpackage

// File: rtl/onehot_bin8.sv
// 8-bit one-hot to binary encoder.
// Lowest set bit wins when several bits are high.
module onehot_bin8 (
  input  logic [7:0] onehot,
  output logic [2:0] bin
);

  logic [7:0] lowest;

  // Isolate the lowest set bit so the case below is truly one-hot.
  assign lowest = onehot & (~onehot + 8'd1);

  always_comb begin
    bin = 3'd0;
    unique case (1'b1)
      lowest[0]: bin = 3'd0;
      lowest[1]: bin = 3'd1;
      lowest[2]: bin = 3'd2;
      lowest[3]: bin = 3'd3;
      lowest[4]: bin = 3'd4;
      lowest[5]: bin = 3'd5;
      lowest[6]: bin = 3'd6;
      lowest[7]: bin = 3'd7;
      default:   bin = 3'd0;
    endcase
  end

endmodule

// File: rtl/tlb_random.sv
// CP0 Random counter: free-running down-counter with rewind.
// TLB_RANDOM_WIRED_EN makes Wired the lower bound and honours wired_we.
module tlb_random
  import tlb_entry_array_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_we,
  output logic [IDX_W-1:0] random
);

  logic [IDX_W-1:0] lb;
  logic [IDX_W-1:0] rnd_nxt;
  logic             rewind;

`ifdef TLB_RANDOM_WIRED_EN
  assign lb     = wired;
  assign rewind = wired_we;
`else
  logic unused_wired;
  assign unused_wired = ^{wired, wired_we};
  assign lb     = '0;
  assign rewind = 1'b0;
`endif

  always_comb begin
    rnd_nxt = random - 1'b1;
    if (rewind || (random <= lb))
      rnd_nxt = RANDOM_RST;
  end

  always_ff @(posedge clk) begin
    if (rst)
      random <= RANDOM_RST;
    else
      random <= rnd_nxt;
  end

endmodule

// File: rtl/tlb_entry_array.sv
// Joint TLB entry array with TLBR/TLBWI/TLBWR/TLBP sequencer.
// TLB_RANDOM_WIRED_EN bounds Random (and so TLBWR) below by Wired.
module tlb_entry_array
  import tlb_entry_array_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  output logic [NENTRY-1:0][TLB_W-1:0] entries,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [1:0]                   op,
  input  logic [IDX_W-1:0]             cp0_index,
  input  logic [26:0]                  cp0_entryhi,
  input  logic [25:0]                  cp0_entrylo0,
  input  logic [25:0]                  cp0_entrylo1,
  input  logic [IDX_W-1:0]             cp0_wired,
  input  logic                         wired_we,
  output logic                         resp_valid,
  output logic [31:0]                  probe_index,
  output logic [TLB_W-1:0]             rd_entry,
  output logic [IDX_W-1:0]             random
);

  state_t            state;
  state_t            state_nxt;
  TLBOp_t            op_t;
  logic              accept;

  TLB_t [NENTRY-1:0] ent_q;
  TLB_t              new_q;
  TLB_t              rd_q;
  logic [IDX_W-1:0]  idx_q;
  logic [26:0]       hi_q;
  logic [NENTRY-1:0] hit;
  logic [NENTRY-1:0] hit_q;
  logic [IDX_W-1:0]  enc;
  logic              done_q;
  Index_t            pi_now;
  Index_t            pi_q;

  assign op_t   = TLBOp_t'(op);
  assign accept = op_valid && op_ready;

  tlb_random u_random (
    .clk,
    .rst,
    .wired    (cp0_wired),
    .wired_we,
    .random
  );

  onehot_bin8 u_enc (
    .onehot (hit_q),
    .bin    (enc)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (op_valid) begin
          case (op_t)
            TLBR:    state_nxt = READ;
            TLBWI:   state_nxt = WRITE;
            TLBWR:   state_nxt = WRITE;
            TLBP:    state_nxt = PROBE;
            default: state_nxt = IDLE;
          endcase
        end
      end
      PROBE:   state_nxt = RESP;
      WRITE:   state_nxt = IDLE;
      READ:    state_nxt = IDLE;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_ready   = (state == IDLE);
    resp_valid = done_q || (state == RESP);
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NENTRY; i++)
      hit[i] = tlb_match(ent_q[i], hi_q);
  end

  always_comb begin
    pi_now       = '0;
    pi_now.p     = ~|hit_q;
    pi_now.index = enc;
  end

  // Op operands are captured once at acceptance; the requester
  // may change cp0_* freely while the op runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q  <= '0;
      new_q  <= '0;
      rd_q   <= '0;
      idx_q  <= '0;
      hi_q   <= '0;
      hit_q  <= '0;
      done_q <= 1'b0;
      pi_q   <= '0;
    end else begin
      done_q <= (state == WRITE) || (state == READ);
      if (accept) begin
        idx_q <= (op_t == TLBWR) ? random : cp0_index;
        hi_q  <= cp0_entryhi;
        new_q <= make_entry(cp0_entryhi,
                            cp0_entrylo0,
                            cp0_entrylo1);
      end
      if (state == WRITE)
        ent_q[idx_q] <= new_q;
      if (state == READ)
        rd_q <= ent_q[idx_q];
      if (state == PROBE)
        hit_q <= hit;
      if (state == RESP)
        pi_q <= pi_now;
    end
  end

  assign entries     = ent_q;
  assign rd_entry    = rd_q;
  assign probe_index = (state == RESP) ? pi_now : pi_q;

endmodule

// File: tb/tb_tlb_entry_array.sv
// Randomised self-checking bench for tlb_entry_array.
// Wired-bound scenario only built with TLB_RANDOM_WIRED_EN.
module tb_tlb_entry_array;

  localparam logic [1:0] OP_R  = 2'd0;
  localparam logic [1:0] OP_WI = 2'd1;
  localparam logic [1:0] OP_WR = 2'd2;
  localparam logic [1:0] OP_P  = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0][77:0] entries;
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       op;
  logic [2:0]       cp0_index;
  logic [26:0]      cp0_entryhi;
  logic [25:0]      cp0_entrylo0;
  logic [25:0]      cp0_entrylo1;
  logic [2:0]       cp0_wired;
  logic             wired_we;
  logic             resp_valid;
  logic [31:0]      probe_index;
  logic [77:0]      rd_entry;
  logic [2:0]       random;

  always #5 clk = ~clk;

  tlb_entry_array dut (
    .clk          (clk),
    .rst          (rst),
    .entries      (entries),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op           (op),
    .cp0_index    (cp0_index),
    .cp0_entryhi  (cp0_entryhi),
    .cp0_entrylo0 (cp0_entrylo0),
    .cp0_entrylo1 (cp0_entrylo1),
    .cp0_wired    (cp0_wired),
    .wired_we     (wired_we),
    .resp_valid   (resp_valid),
    .probe_index  (probe_index),
    .rd_entry     (rd_entry),
    .random       (random)
  );

  int checks = 0;
  int passed = 0;

  // Reference model state
  int          k = 0;
  int          base = 0;
  int          lb = 0;
  logic [77:0] m_ent [8];

  logic [7:0][77:0] mid_snap;
  logic [2:0]       mid_rand;
  logic [2:0]       mid_exp;
  logic [2:0]       acc_exp;
  logic [77:0]      res_rd;
  logic [31:0]      res_pi;
  int               lat;

  always @(posedge clk) begin
    if (rst) begin
      k    <= 0;
      base <= 0;
      lb   <= 0;
    end else begin
      k <= k + 1;
`ifdef TLB_RANDOM_WIRED_EN
      if (wired_we) begin
        base <= k + 1;
        lb   <= int'(cp0_wired);
      end
`endif
    end
  end

  function automatic logic [2:0] exp_rand();
    return 3'(7 - ((k - base) % (8 - lb)));
  endfunction

  function automatic logic [77:0] mk(input logic [26:0] hi,
                                     input logic [25:0] l0,
                                     input logic [25:0] l1);
    return {hi[26:8], hi[7:0], l0[0] & l1[0],
            l0[25:6], l0[5:3], l0[2], l0[1],
            l1[25:6], l1[5:3], l1[2], l1[1]};
  endfunction

  function automatic logic [31:0] exp_probe(input logic [26:0] hi);
    for (int i = 0; i < 8; i++) begin
      if (m_ent[i][77:59] == hi[26:8] &&
          (m_ent[i][50] || m_ent[i][58:51] == hi[7:0]))
        return {29'd0, 3'(i)};
    end
    return 32'h8000_0000;
  endfunction

  task automatic run_op(input logic [1:0]  o,
                        input logic [2:0]  idx,
                        input logic [26:0] hi,
                        input logic [25:0] l0,
                        input logic [25:0] l1);
    logic [2:0] tgt;
    for (int n = 0; n < 20 && !op_ready; n++) @(negedge clk);
    op_valid = 1'b1;
    op = o;
    cp0_index = idx;
    cp0_entryhi = hi;
    cp0_entrylo0 = l0;
    cp0_entrylo1 = l1;
    acc_exp = exp_rand();
    @(negedge clk);
    op_valid = 1'b0;
    op = 2'($urandom);
    cp0_index = 3'($urandom);
    cp0_entryhi = 27'($urandom);
    cp0_entrylo0 = 26'($urandom);
    cp0_entrylo1 = 26'($urandom);
    mid_snap = entries;
    mid_rand = random;
    mid_exp = exp_rand();
    lat = 99;
    for (int n = 1; n < 10; n++) begin
      if (resp_valid) begin
        lat = n;
        res_rd = rd_entry;
        res_pi = probe_index;
        break;
      end
      @(negedge clk);
    end
    tgt = (o == OP_WR) ? acc_exp : idx;
    if (o == OP_WI || o == OP_WR)
      m_ent[tgt] = mk(hi, l0, l1);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    op_valid = 1'b0;
    op = 2'd0;
    cp0_index = '0;
    cp0_entryhi = '0;
    cp0_entrylo0 = '0;
    cp0_entrylo1 = '0;
    cp0_wired = '0;
    wired_we = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_ent[i] = '0;
    checks++;
    if (op_ready !== 1'b1)
      $display("FAIL reset_op_ready got %b want 1", op_ready);
    else passed++;
    checks++;
    if (resp_valid !== 1'b0)
      $display("FAIL reset_resp_valid got %b want 0", resp_valid);
    else passed++;
    checks++;
    if (probe_index !== 32'd0)
      $display("FAIL reset_probe_index got %h want 0", probe_index);
    else passed++;
    checks++;
    if (rd_entry !== 78'd0)
      $display("FAIL reset_rd_entry got %h want 0", rd_entry);
    else passed++;
    checks++;
    if (random !== 3'd7)
      $display("FAIL reset_random got %0d want 7", random);
    else passed++;
    bad = -1;
    for (int i = 0; i < 8; i++)
      if (bad < 0 && entries[i] !== m_ent[i]) bad = i;
    checks++;
    if (bad >= 0)
      $display("FAIL reset_entries[%0d] got %h want %h",
               bad, entries[bad], m_ent[bad]);
    else passed++;
  endtask

  task automatic test_random_seq();
    logic [2:0] seq [10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
    int bad;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (random !== seq[i])
        $display("FAIL random_seq[%0d] got %0d want %0d",
                 i, random, seq[i]);
      else passed++;
      @(negedge clk);
    end
    bad = -1;
    for (int i = 0; i < 8; i++)
      if (bad < 0 && entries[i] !== 78'd0) bad = i;
    checks++;
    if (bad >= 0)
      $display("FAIL idle_entries[%0d] got %h want 0",
               bad, entries[bad]);
    else passed++;
  endtask

  task automatic test_write_read();
    logic [26:0] hi = {19'h12345, 8'h05};
    logic [25:0] l0 = {20'habcde, 3'd3, 1'b1, 1'b1, 1'b1};
    logic [25:0] l1 = {20'h13579, 3'd2, 1'b0, 1'b1, 1'b1};
    int bad;
    run_op(OP_WI, 3'd3, hi, l0, l1);
    checks++;
    if (lat !== 2)
      $display("FAIL wi_latency got %0d want 2", lat);
    else passed++;
    checks++;
    if (mid_snap[3] !== 78'd0)
      $display("FAIL wi_old_during_write got %h want 0", mid_snap[3]);
    else passed++;
    checks++;
    if (entries[3][50] !== 1'b1)
      $display("FAIL wi_g_bit got %b want 1", entries[3][50]);
    else passed++;
    bad = -1;
    for (int i = 0; i < 8; i++)
      if (bad < 0 && entries[i] !== m_ent[i]) bad = i;
    checks++;
    if (bad >= 0)
      $display("FAIL wi_entries[%0d] got %h want %h",
               bad, entries[bad], m_ent[bad]);
    else passed++;
    run_op(OP_R, 3'd3, 27'($urandom), 26'($urandom), 26'($urandom));
    checks++;
    if (lat !== 2)
      $display("FAIL tlbr_latency got %0d want 2", lat);
    else passed++;
    checks++;
    if (res_rd !== m_ent[3])
      $display("FAIL tlbr_data got %h want %h", res_rd, m_ent[3]);
    else passed++;
    run_op(OP_R, 3'd6, 27'($urandom), 26'($urandom), 26'($urandom));
    checks++;
    if (res_rd !== m_ent[6])
      $display("FAIL tlbr_empty got %h want %h", res_rd, m_ent[6]);
    else passed++;
  endtask

  task automatic test_probe();
    logic [26:0] hi = {19'h12345, 8'h05};
    logic [25:0] l0 = {20'habcde, 3'd3, 1'b1, 1'b1, 1'b0};
    logic [25:0] l1 = {20'h13579, 3'd2, 1'b0, 1'b1, 1'b1};
    run_op(OP_P, 3'($urandom), {19'h12345, 8'h09},
           26'($urandom), 26'($urandom));
    checks++;
    if (lat !== 2)
      $display("FAIL tlbp_latency got %0d want 2", lat);
    else passed++;
    checks++;
    if (res_pi !== 32'h0000_0003)
      $display("FAIL tlbp_global_hit got %h want 00000003", res_pi);
    else passed++;
    run_op(OP_WI, 3'd3, hi, l0, l1);
    run_op(OP_P, 3'($urandom), {19'h12345, 8'h09},
           26'($urandom), 26'($urandom));
    checks++;
    if (res_pi !== 32'h8000_0000)
      $display("FAIL tlbp_asid_miss got %h want 80000000", res_pi);
    else passed++;
    run_op(OP_P, 3'($urandom), hi, 26'($urandom), 26'($urandom));
    checks++;
    if (res_pi !== exp_probe(hi))
      $display("FAIL tlbp_asid_hit got %h want %h",
               res_pi, exp_probe(hi));
    else passed++;
  endtask

  task automatic test_tlbwr();
    logic [26:0] hi = {19'h2aaaa, 8'h33};
    int bad;
    for (int n = 0; n < 40; n++) begin
      if (exp_rand() == 3'd5 && op_ready) break;
      @(negedge clk);
    end
    checks++;
    if (random !== 3'd5 || op_ready !== 1'b1)
      $display("FAIL tlbwr_setup got rnd=%0d rdy=%b want 5/1",
               random, op_ready);
    else passed++;
    run_op(OP_WR, 3'd0, hi, 26'($urandom), 26'($urandom));
    checks++;
    if (mid_rand !== mid_exp)
      $display("FAIL tlbwr_random_mid got %0d want %0d",
               mid_rand, mid_exp);
    else passed++;
    checks++;
    if (random !== exp_rand())
      $display("FAIL tlbwr_random_resp got %0d want %0d",
               random, exp_rand());
    else passed++;
    checks++;
    if (entries[5] !== m_ent[5])
      $display("FAIL tlbwr_entry5 got %h want %h",
               entries[5], m_ent[5]);
    else passed++;
    bad = -1;
    for (int i = 0; i < 8; i++)
      if (bad < 0 && entries[i] !== m_ent[i]) bad = i;
    checks++;
    if (bad >= 0)
      $display("FAIL tlbwr_entries[%0d] got %h want %h",
               bad, entries[bad], m_ent[bad]);
    else passed++;
  endtask

  task automatic test_random_ops();
    logic [18:0] vpns [3] = '{19'h12345, 19'h00abc, 19'h7ffff};
    logic [1:0]  o;
    logic [2:0]  idx;
    logic [26:0] hi;
    int bad;
    for (int it = 0; it < 40; it++) begin
      o = 2'($urandom_range(0, 3));
      idx = 3'($urandom);
      hi = {vpns[$urandom_range(0, 2)], 8'($urandom_range(1, 2))};
      run_op(o, idx, hi, 26'($urandom), 26'($urandom));
      checks++;
      if (lat !== 2)
        $display("FAIL rnd_latency[%0d] got %0d want 2", it, lat);
      else passed++;
      if (o == OP_R) begin
        checks++;
        if (res_rd !== m_ent[idx])
          $display("FAIL rnd_tlbr[%0d] got %h want %h",
                   it, res_rd, m_ent[idx]);
        else passed++;
      end
      if (o == OP_P) begin
        checks++;
        if (res_pi !== exp_probe(hi))
          $display("FAIL rnd_tlbp[%0d] got %h want %h",
                   it, res_pi, exp_probe(hi));
        else passed++;
      end
      bad = -1;
      for (int i = 0; i < 8; i++)
        if (bad < 0 && entries[i] !== m_ent[i]) bad = i;
      checks++;
      if (bad >= 0)
        $display("FAIL rnd_entries[%0d][%0d] got %h want %h",
                 it, bad, entries[bad], m_ent[bad]);
      else passed++;
      checks++;
      if (random !== exp_rand())
        $display("FAIL rnd_random[%0d] got %0d want %0d",
                 it, random, exp_rand());
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    for (int n = 0; n < 20 && !op_ready; n++) @(negedge clk);
    op_valid = 1'b1;
    op = OP_P;
    cp0_entryhi = {19'h12345, 8'h05};
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b0)
      $display("FAIL hold_ready_probe got %b want 0", op_ready);
    else passed++;
    op = OP_R;
    cp0_index = 3'd3;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b0 || resp_valid !== 1'b1)
      $display("FAIL hold_ready_resp got rdy=%b resp=%b want 0/1",
               op_ready, resp_valid);
    else passed++;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1)
      $display("FAIL hold_ready_idle got %b want 1", op_ready);
    else passed++;
    @(negedge clk);
    op_valid = 1'b0;
    checks++;
    if (op_ready !== 1'b0)
      $display("FAIL hold_in_read got %b want 0", op_ready);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_ent[i] = '0;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (resp_valid !== 1'b0)
        $display("FAIL abort_resp[%0d] got %b want 0", n, resp_valid);
      else passed++;
      @(negedge clk);
    end
    checks++;
    if (rd_entry !== 78'd0)
      $display("FAIL abort_rd_entry got %h want 0", rd_entry);
    else passed++;
    checks++;
    if (random !== exp_rand())
      $display("FAIL abort_random got %0d want %0d",
               random, exp_rand());
    else passed++;
    bad = -1;
    for (int i = 0; i < 8; i++)
      if (bad < 0 && entries[i] !== m_ent[i]) bad = i;
    checks++;
    if (bad >= 0)
      $display("FAIL abort_entries[%0d] got %h want %h",
               bad, entries[bad], m_ent[bad]);
    else passed++;
  endtask

  task automatic test_wired();
    int bad;
    logic [2:0] seq [8] = '{7, 6, 5, 4, 7, 6, 5, 4};
    logic [7:0][77:0] snap;
    for (int n = 0; n < 20 && !op_ready; n++) @(negedge clk);
    cp0_wired = 3'd4;
    wired_we = 1'b1;
    @(negedge clk);
    wired_we = 1'b0;
`ifdef TLB_RANDOM_WIRED_EN
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (random !== seq[i])
        $display("FAIL wired_seq[%0d] got %0d want %0d",
                 i, random, seq[i]);
      else passed++;
      @(negedge clk);
    end
    snap = entries;
    for (int it = 0; it < 50; it++) begin
      run_op(OP_WR, 3'($urandom), 27'($urandom),
             26'($urandom), 26'($urandom));
      bad = -1;
      for (int i = 0; i < 4; i++)
        if (bad < 0 && entries[i] !== snap[i]) bad = i;
      checks++;
      if (bad >= 0)
        $display("FAIL wired_protect[%0d][%0d] got %h want %h",
                 it, bad, entries[bad], snap[bad]);
      else passed++;
    end
`else
    snap = entries;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (random !== exp_rand() || seq[0] !== 3'd7)
        $display("FAIL wired_ignored[%0d] got %0d want %0d",
                 i, random, exp_rand());
      else passed++;
      @(negedge clk);
    end
    for (int it = 0; it < 10; it++)
      run_op(OP_WR, 3'($urandom), 27'($urandom),
             26'($urandom), 26'($urandom));
    checks++;
    if (entries === snap)
      $display("FAIL wired_tlbwr_no_change got %h want change",
               entries[0]);
    else passed++;
`endif
    bad = -1;
    for (int i = 0; i < 8; i++)
      if (bad < 0 && entries[i] !== m_ent[i]) bad = i;
    checks++;
    if (bad >= 0)
      $display("FAIL wired_entries[%0d] got %h want %h",
               bad, entries[bad], m_ent[bad]);
    else passed++;
    checks++;
    if (random !== exp_rand())
      $display("FAIL wired_random_end got %0d want %0d",
               random, exp_rand());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_random_seq();
    test_write_read();
    test_probe();
    test_tlbwr();
    test_random_ops();
    test_back_to_back();
    test_wired();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
